univ_reg: RTL and testbench
===========================

Name: univ_reg

Overview:
- Parametrised universal register, successor to the team's single-bit inferred flip-flop set.
- Combines sync clear, sync reset, sync preset, clock enable, parallel load, shift, rotate and up/down count on one WIDTH-bit register.
- Outputs serial shift-outs plus zero, wrap and overflow status flags.
- Used as a general datapath and control register across the design, wherever multiple q-style flops were previously hand-instantiated.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- RESET_VAL, 0, value loaded into q on clr.
- PRESET_VAL, all ones ({WIDTH{1'b1}}), value loaded into q on pre.
- SHIFT_AMT, 1, bit positions moved per shift or rotate; legal range is 1 to WIDTH-1.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- clr  input  1  Synchronous, active-low reset; highest priority.
- synch_reset  input  1  Synchronous clear, active-low; forces q to 0; ignores clock_enable.
- pre  input  1  Synchronous preset, active-high; ignores clock_enable.
- clock_enable  input  1  Active-high enable for mode operations.
- mode  input  3  Operation select (see Behaviour).
- data  input  WIDTH  Parallel load value.
- sin_r  input  SHIFT_AMT  Serial bits shifted into the LSBs on shift left.
- sin_l  input  SHIFT_AMT  Serial bits shifted into the MSBs on shift right.
- q  output  WIDTH  Registered value.
- sout_l  output  SHIFT_AMT  Combinational; equals q[WIDTH-1 -: SHIFT_AMT].
- sout_r  output  SHIFT_AMT  Combinational; equals q[SHIFT_AMT-1:0].
- zero  output  1  Registered; high when q==0.
- wrap  output  1  Registered one-cycle pulse on a count wrap.
- ovf  output  1  Sticky; set on any count wrap.

Behaviour:
- Interface: one clock (clk); clr is synchronous and active-low.
- Reset values on clr low at a clk edge:
  - q=RESET_VAL
  - zero=(RESET_VAL==0)
  - wrap=0
  - ovf=0
- Priority per rising clk edge, evaluated in this order:
  1. clr==0
  2. synch_reset==0: q=0, zero=1, wrap=0, ovf=0
  3. pre==1: q=PRESET_VAL, wrap=0, ovf held
  4. clock_enable==1: mode operation
  5. otherwise: q held, wrap=0, ovf held
- Mode operations (when clock_enable==1):
  - 000 hold
  - 001 load: q<=data
  - 010 shift left: q<={q[WIDTH-1-SHIFT_AMT:0], sin_r}
  - 011 shift right: q<={sin_l, q[WIDTH-1:SHIFT_AMT]}
  - 100 rotate left by SHIFT_AMT
  - 101 rotate right by SHIFT_AMT
  - 110 count up: q<=q+1, modulo 2^WIDTH
  - 111 count down: q<=q-1, modulo 2^WIDTH
- Wrap and overflow:
  - wrap is high for exactly the cycle after q steps all ones to 0 (up) or 0 to all ones (down).
  - ovf is set at the same edge as wrap and stays set until clr or synch_reset.
  - A non-count mode forces wrap=0 on the next edge.
- zero: registered alongside q (it reflects the new q); it has the same latency as q.
- Latency:
  - All operations take effect 1 cycle after the edge at which they are sampled.
  - sout_l and sout_r are combinational from q, with no added latency.
- Simultaneous controls:
  - pre together with synch_reset low: the reset wins.
  - pre together with clock_enable: the preset wins and mode is ignored.
  - clr low mid-count: the count is abandoned and wrap is not pulsed that cycle.
- No asynchronous paths: clr, synch_reset and pre have no effect between clk edges.
- Parameter check: an illegal SHIFT_AMT or WIDTH causes an elaboration-time error (generate-time check).

Test Plan (all scenarios use WIDTH=8, RESET_VAL=8'h00, PRESET_VAL=8'hFF, SHIFT_AMT=1):
1. Reset and load: clr=0 for 2 cycles -> q=00, zero=1, ovf=0. Then clr=1, ce=1, mode=001, data=A5 -> q=A5 next cycle, zero=0.
2. Shift: q=A5, mode=010, sin_r=1 -> q=4B with sout_l=1 before the edge. Then mode=011, sin_l=0 -> q=25.
3. Rotate: q=81, mode=100 -> 03; mode=101 from 03 -> 81.
4. Count up with wrap: load FE, mode=110 for 3 cycles -> q=FF, 00 (wrap=1 one cycle, ovf=1), 01 (wrap=0, ovf=1). synch_reset=0 -> q=00, ovf=0.
5. Priority: ce=1, mode=001, data=3C, pre=1 -> q=FF. pre=1 with synch_reset=0 -> q=00. clr=0 with all others asserted -> q=00, ovf=0.
6. Enable gating and count down: ce=0, mode=111 for 4 cycles -> q unchanged. ce=1 from 00 -> FF, wrap=1, ovf=1.

Source files
------------

// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: clear, preset, parallel load, shift, rotate and up/down count,
// with serial shift-outs and registered zero / wrap / sticky overflow status.
module univ_reg #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
   parameter int               SHIFT_AMT  = 1
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 synch_reset,
   input  logic                 pre,
   input  logic                 clock_enable,
   input  logic [2:0]           mode,
   input  logic [WIDTH-1:0]     data,
   input  logic [SHIFT_AMT-1:0] sin_r,
   input  logic [SHIFT_AMT-1:0] sin_l,
   output logic [WIDTH-1:0]     q,
   output logic [SHIFT_AMT-1:0] sout_l,
   output logic [SHIFT_AMT-1:0] sout_r,
   output logic                 zero,
   output logic                 wrap,
   output logic                 ovf
);

   localparam logic [WIDTH-1:0] ONE = 1;

   generate
      if (WIDTH < 2 || SHIFT_AMT < 1 || SHIFT_AMT > WIDTH - 1) begin : g_bad_param
         $error("univ_reg: illegal WIDTH/SHIFT_AMT combination");
      end
   endgenerate

   logic [WIDTH-1:0] r_q;
   logic             r_zero;
   logic             r_wrap;
   logic             r_ovf;

   logic [WIDTH-1:0] w_q_next;
   logic             w_wrap_next;
   logic             w_ovf_next;

   // Everything below clr in priority; clr itself is applied in the register process.
   always_comb begin
      w_q_next    = r_q;
      w_wrap_next = 1'b0;
      w_ovf_next  = r_ovf;
      if (!synch_reset) begin
         w_q_next   = '0;
         w_ovf_next = 1'b0;
      end else if (pre) begin
         w_q_next = PRESET_VAL;
      end else if (clock_enable) begin
         case (mode)
            3'b001: w_q_next = data;
            3'b010: w_q_next = {r_q[WIDTH-1-SHIFT_AMT:0], sin_r};
            3'b011: w_q_next = {sin_l, r_q[WIDTH-1:SHIFT_AMT]};
            3'b100: w_q_next = {r_q[WIDTH-1-SHIFT_AMT:0], r_q[WIDTH-1 -: SHIFT_AMT]};
            3'b101: w_q_next = {r_q[SHIFT_AMT-1:0], r_q[WIDTH-1:SHIFT_AMT]};
            3'b110: begin
               w_q_next    = r_q + ONE;
               w_wrap_next = &r_q;
               w_ovf_next  = r_ovf | (&r_q);
            end
            3'b111: begin
               w_q_next    = r_q - ONE;
               w_wrap_next = ~|r_q;
               w_ovf_next  = r_ovf | (~|r_q);
            end
            default: w_q_next = r_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_q    <= RESET_VAL;
         r_zero <= (RESET_VAL == '0);
         r_wrap <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_q    <= w_q_next;
         r_zero <= (w_q_next == '0);
         r_wrap <= w_wrap_next;
         r_ovf  <= w_ovf_next;
      end
   end

   assign q      = r_q;
   assign zero   = r_zero;
   assign wrap   = r_wrap;
   assign ovf    = r_ovf;
   assign sout_l = r_q[WIDTH-1 -: SHIFT_AMT];
   assign sout_r = r_q[SHIFT_AMT-1:0];

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg (WIDTH=8, SHIFT_AMT=1): directed scenarios plus a random phase.
module tb_univ_reg;

   logic       clk;
   logic       clr;
   logic       synch_reset;
   logic       pre;
   logic       clock_enable;
   logic [2:0] mode;
   logic [7:0] data;
   logic [0:0] sin_r;
   logic [0:0] sin_l;
   logic [7:0] q;
   logic [0:0] sout_l;
   logic [0:0] sout_r;
   logic       zero;
   logic       wrap;
   logic       ovf;

   univ_reg #(
      .WIDTH      (8),
      .RESET_VAL  (8'h00),
      .PRESET_VAL (8'hFF),
      .SHIFT_AMT  (1)
   ) dut (
      .clk          (clk),
      .clr          (clr),
      .synch_reset  (synch_reset),
      .pre          (pre),
      .clock_enable (clock_enable),
      .mode         (mode),
      .data         (data),
      .sin_r        (sin_r),
      .sin_l        (sin_l),
      .q            (q),
      .sout_l       (sout_l),
      .sout_r       (sout_r),
      .zero         (zero),
      .wrap         (wrap),
      .ovf          (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] q;
      logic       zero;
      logic       wrap;
      logic       ovf;
      logic       use_plan;
      logic [7:0] plan_q;
   } exp_t;

   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] m_q;
   logic       m_wrap;
   logic       m_ovf;
   logic       m_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input string tag, input logic c_clr, input logic c_sr, input logic c_pre,
                       input logic c_ce, input logic [2:0] c_mode, input logic [7:0] c_data,
                       input logic c_sinr, input logic c_sinl,
                       input logic use_plan, input logic [7:0] plan_q);
      exp_t e;
      @(negedge clk);
      clr          = c_clr;
      synch_reset  = c_sr;
      pre          = c_pre;
      clock_enable = c_ce;
      mode         = c_mode;
      data         = c_data;
      sin_r        = c_sinr;
      sin_l        = c_sinl;
      #1;
      if (m_valid) begin
         chk({tag, "_sout_l_pre"}, {31'd0, sout_l}, {31'd0, m_q[7]});
         chk({tag, "_sout_r_pre"}, {31'd0, sout_r}, {31'd0, m_q[0]});
      end
      // advance the model
      if (!c_clr || !c_sr) begin
         m_q = 8'h00; m_wrap = 1'b0; m_ovf = 1'b0;
      end else if (c_pre) begin
         m_q = 8'hFF; m_wrap = 1'b0;
      end else if (c_ce) begin
         m_wrap = 1'b0;
         case (c_mode)
            3'd1: m_q = c_data;
            3'd2: m_q = {m_q[6:0], c_sinr};
            3'd3: m_q = {c_sinl, m_q[7:1]};
            3'd4: m_q = {m_q[6:0], m_q[7]};
            3'd5: m_q = {m_q[0], m_q[7:1]};
            3'd6: begin m_wrap = (m_q == 8'hFF); m_q = m_q + 8'd1; end
            3'd7: begin m_wrap = (m_q == 8'h00); m_q = m_q - 8'd1; end
            default: ;
         endcase
         if (m_wrap) m_ovf = 1'b1;
      end else begin
         m_wrap = 1'b0;
      end
      m_valid    = 1'b1;
      e.q        = m_q;
      e.zero     = (m_q == 8'h00);
      e.wrap     = m_wrap;
      e.ovf      = m_ovf;
      e.use_plan = use_plan;
      e.plan_q   = plan_q;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      $display("[TB] %s: q=%02h zero=%0b wrap=%0b ovf=%0b (exp q=%02h)", tag, q, zero, wrap, ovf, e.q);
      chk({tag, "_q"},    {24'd0, q},      {24'd0, e.q});
      chk({tag, "_zero"}, {31'd0, zero},   {31'd0, e.zero});
      chk({tag, "_wrap"}, {31'd0, wrap},   {31'd0, e.wrap});
      chk({tag, "_ovf"},  {31'd0, ovf},    {31'd0, e.ovf});
      chk({tag, "_soutl"}, {31'd0, sout_l}, {31'd0, e.q[7]});
      chk({tag, "_soutr"}, {31'd0, sout_r}, {31'd0, e.q[0]});
      if (e.use_plan) chk({tag, "_plan_q"}, {24'd0, q}, {24'd0, e.plan_q});
   endtask

   initial begin
      clr = 1'b0; synch_reset = 1'b1; pre = 1'b0; clock_enable = 1'b0;
      mode = 3'd0; data = 8'h00; sin_r = 1'b0; sin_l = 1'b0;

      // 1. reset and load
      step("rst0",  0, 1, 0, 0, 3'd0, 8'h00, 0, 0, 1, 8'h00);
      step("rst1",  0, 1, 0, 0, 3'd0, 8'h00, 0, 0, 1, 8'h00);
      step("ldA5",  1, 1, 0, 1, 3'd1, 8'hA5, 0, 0, 1, 8'hA5);
      // 2. shift
      step("shl",   1, 1, 0, 1, 3'd2, 8'h00, 1, 0, 1, 8'h4B);
      step("shr",   1, 1, 0, 1, 3'd3, 8'h00, 0, 0, 1, 8'h25);
      // 3. rotate
      step("ld81",  1, 1, 0, 1, 3'd1, 8'h81, 0, 0, 1, 8'h81);
      step("rol",   1, 1, 0, 1, 3'd4, 8'h00, 0, 0, 1, 8'h03);
      step("ror",   1, 1, 0, 1, 3'd5, 8'h00, 0, 0, 1, 8'h81);
      // 4. count up with wrap; preset keeps ovf, synch_reset clears it
      step("ldFE",  1, 1, 0, 1, 3'd1, 8'hFE, 0, 0, 1, 8'hFE);
      step("up1",   1, 1, 0, 1, 3'd6, 8'h00, 0, 0, 1, 8'hFF);
      step("up2",   1, 1, 0, 1, 3'd6, 8'h00, 0, 0, 1, 8'h00);
      step("up3",   1, 1, 0, 1, 3'd6, 8'h00, 0, 0, 1, 8'h01);
      step("preov", 1, 1, 1, 0, 3'd0, 8'h00, 0, 0, 1, 8'hFF);
      step("srst",  1, 0, 0, 1, 3'd6, 8'h00, 0, 0, 1, 8'h00);
      // 5. priority
      step("preld", 1, 1, 1, 1, 3'd1, 8'h3C, 0, 0, 1, 8'hFF);
      step("presr", 1, 0, 1, 1, 3'd1, 8'h3C, 0, 0, 1, 8'h00);
      step("ldFF",  1, 1, 0, 1, 3'd1, 8'hFF, 0, 0, 1, 8'hFF);
      step("upw",   1, 1, 0, 1, 3'd6, 8'h00, 0, 0, 1, 8'h00);
      step("clrall",0, 0, 1, 1, 3'd1, 8'h3C, 1, 1, 1, 8'h00);
      // clr mid-count at the wrap point: no wrap pulse
      step("ldFF2", 1, 1, 0, 1, 3'd1, 8'hFF, 0, 0, 1, 8'hFF);
      step("clrcnt",0, 1, 0, 1, 3'd6, 8'h00, 0, 0, 1, 8'h00);
      // 6. enable gating and count down
      for (int i = 0; i < 4; i++)
         step("ce0",  1, 1, 0, 0, 3'd7, 8'h00, 0, 0, 1, 8'h00);
      step("dn1",   1, 1, 0, 1, 3'd7, 8'h00, 0, 0, 1, 8'hFF);
      step("dn2",   1, 1, 0, 1, 3'd7, 8'h00, 0, 0, 1, 8'hFE);

      // random phase, model only
      for (int i = 0; i < 80; i++) begin
         step("rnd",
              ($urandom_range(0, 19) != 0),
              ($urandom_range(0, 14) != 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 4) != 0),
              3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              0, 8'h00);
      end

      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
